sram_uart_dma: RTL
==================

SRAM_UART_DMA -- requirements
Module: sram_uart_dma

Interface
REQ-001 SHALL have parameter AW, default 3, SRAM address width.
REQ-002 SHALL have parameter BAUD_DIV, default 130, the value written to the UART baud register.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, the watchdog limit in clocks.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr, input, AW bits: the first SRAM address.
REQ-008 SHALL have port len, input, AW+1 bits: the byte count, 0..2^AW.
REQ-009 SHALL have port sram_addr, output, AW bits: the SRAM address.
REQ-010 SHALL have port sram_re, output, 1 bit: the SRAM read enable.
REQ-011 SHALL have port sram_rdata, input, 8 bits: SRAM read data, valid one cycle after sram_re.
REQ-012 SHALL have port uart_addr, output, 2 bits: the UART register select.
REQ-013 SHALL have port uart_wdata, output, 8 bits: UART write data.
REQ-014 SHALL have port uart_we, output, 1 bit: UART write strobe, one cycle per write.
REQ-015 SHALL have port uart_tx_busy, input, 1 bit: high while the UART shifts a frame.
REQ-016 SHALL have port busy, output, 1 bit: high from accepted start to done.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.
REQ-018 SHALL have port sent_cnt, output, AW+1 bits: bytes completed.

Function
REQ-019 SHALL ignore start unless in IDLE; on an accepted start it SHALL latch base_addr and len, clear sent_cnt and enter CFG_BAUD.
REQ-020 CFG_BAUD SHALL write uart_addr=0, uart_wdata=BAUD_DIV[7:0] for one cycle, then enter CFG_CTRL.
REQ-021 CFG_CTRL SHALL write uart_addr=1, uart_wdata=8'h80, then enter RD_REQ, or DONE if the latched len=0.
REQ-022 RD_REQ SHALL assert sram_re for one cycle at the current address; RD_WAIT SHALL capture sram_rdata on the next cycle.
REQ-023 WR_DATA SHALL write uart_addr=2 with the captured byte; WR_GO SHALL then write uart_addr=1, 8'h80.
REQ-024 WAIT_START SHALL hold until uart_tx_busy=1; WAIT_TX SHALL then hold until uart_tx_busy=0.
REQ-025 On leaving WAIT_TX it SHALL increment sent_cnt and the address (modulo 2^AW, wrapping 7->0 at AW=3), then go to RD_REQ if sent_cnt<len, otherwise to DONE.
REQ-026 DONE SHALL pulse done for exactly one cycle, drop busy, and return to IDLE.
REQ-027 At most one of sram_re and uart_we SHALL be high in any cycle; uart_we SHALL never be high in IDLE, the WAIT states or DONE.
REQ-028 A start arriving in the same cycle as done SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE on the next edge, including mid-transfer; an interrupted byte is abandoned.
REQ-030 Reset values SHALL be: busy=0, done=0, sram_re=0, uart_we=0, sram_addr=0, uart_addr=0, uart_wdata=0, sent_cnt=0.

Configuration
REQ-031 With SRAM_UART_DMA_TIMEOUT_EN defined, a watchdog counter SHALL clear on entry to WAIT_START and to WAIT_TX.
REQ-032 With the macro defined, a counter reaching TIMEOUT_CYC SHALL abort to DONE and set a sticky output err, cleared by the next accepted start or by rst.
REQ-033 Without the macro, there SHALL be no err port and no counter, and the wait states SHALL wait indefinitely.

Structure
REQ-034 Package sram_uart_pkg SHALL hold the state enum and the constants UART_REG_BAUD=0, UART_REG_CTRL=1, UART_REG_TXD=2, UART_REG_CFG=3 and CTRL_TX_GO=8'h80.
REQ-035 Sub-module dma_watchdog SHALL hold the timeout counter and be instantiated only under the macro.

Verification
REQ-036 start, base=0, len=1, byte 0x69 at SRAM[0], busy modeled for 10 cycles -> UART writes (0,130), (1,0x80), (2,0x69), (1,0x80); done once; sent_cnt=1.
REQ-037 base=6, len=3 -> sram_addr sequence 6,7,0; three TXD writes in order.
REQ-038 len=0 -> only the BAUD and CTRL writes; done pulses; sent_cnt=0.
REQ-039 rst asserted during WAIT_TX of byte 2 -> next cycle IDLE, all outputs at reset values, no further writes.
REQ-040 Second start during busy -> ignored; byte count unchanged.
REQ-041 With the macro, uart_tx_busy held low -> after 4096 cycles done pulses and err=1.

Source files
------------

// File: rtl/sram_uart_pkg.sv
// Shared types and register map for the SRAM-to-UART DMA engine.
// UART register offsets and the control value that launches a transmit.
package sram_uart_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CFG_BAUD   = 4'd1,
        ST_CFG_CTRL   = 4'd2,
        ST_RD_REQ     = 4'd3,
        ST_RD_WAIT    = 4'd4,
        ST_WR_DATA    = 4'd5,
        ST_WR_GO      = 4'd6,
        ST_WAIT_START = 4'd7,
        ST_WAIT_TX    = 4'd8,
        ST_DONE       = 4'd9
    } state_t;

    localparam logic [1:0] UART_REG_BAUD = 2'd0;
    localparam logic [1:0] UART_REG_CTRL = 2'd1;
    localparam logic [1:0] UART_REG_TXD  = 2'd2;
    localparam logic [1:0] UART_REG_CFG  = 2'd3;

    localparam logic [7:0] CTRL_TX_GO = 8'h80;

endpackage

// File: rtl/dma_watchdog.sv
// Wait-state timeout counter for sram_uart_dma; only built when
// SRAM_UART_DMA_TIMEOUT_EN is defined.
module dma_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          at_limit;

    assign at_limit = (cnt_q == CW'(TIMEOUT_CYC));
    assign timeout  = run && at_limit;

    // Saturates at the limit so a stalled FSM keeps seeing the timeout.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (run && !at_limit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sram_uart_dma.sv
// Streams len bytes from SRAM into a memory-mapped UART, one frame at a time.
// Define SRAM_UART_DMA_TIMEOUT_EN to add the wait-state watchdog and err output.
module sram_uart_dma
    import sram_uart_pkg::*;
#(
    parameter int AW          = 3,
    parameter int BAUD_DIV    = 130,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic [AW-1:0] sram_addr,
    output logic          sram_re,
    input  logic [7:0]    sram_rdata,
    output logic [1:0]    uart_addr,
    output logic [7:0]    uart_wdata,
    output logic          uart_we,
    input  logic          uart_tx_busy,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   sent_cnt,
`ifdef SRAM_UART_DMA_TIMEOUT_EN
    output logic          err,
`endif
    output state_t        dbg_state
);

    localparam logic [7:0] BAUD_LO = 8'(BAUD_DIV);

    // sram_re and uart_we are single-cycle strobes with no back-pressure:
    // SRAM data is sampled one cycle after sram_re, and UART completion is
    // observed only through uart_tx_busy rising and then falling.

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   len_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_inc;
    logic [7:0]    data_q;
    logic          accept;
    logic          byte_done;
    logic          in_wait;
    logic          wd_timeout;

    assign accept    = (state_q == ST_IDLE) && start;
    assign byte_done = (state_q == ST_WAIT_TX) && !uart_tx_busy;
    assign in_wait   = (state_q == ST_WAIT_START) || (state_q == ST_WAIT_TX);
    assign cnt_inc   = cnt_q + 1'b1;

`ifdef SRAM_UART_DMA_TIMEOUT_EN
    logic wd_clear;
    logic err_q;

    // Restart the count on every entry into a wait state.
    assign wd_clear = ((state_q != ST_WAIT_START) && (state_d == ST_WAIT_START)) ||
                      ((state_q == ST_WAIT_START) && (state_d == ST_WAIT_TX));

    dma_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .run     (in_wait),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_q <= 1'b0;
        end else if (in_wait && wd_timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign wd_timeout         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (start) state_d = ST_CFG_BAUD;
            ST_CFG_BAUD:   state_d = ST_CFG_CTRL;
            ST_CFG_CTRL:   state_d = (len_q == '0) ? ST_DONE : ST_RD_REQ;
            ST_RD_REQ:     state_d = ST_RD_WAIT;
            ST_RD_WAIT:    state_d = ST_WR_DATA;
            ST_WR_DATA:    state_d = ST_WR_GO;
            ST_WR_GO:      state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (uart_tx_busy)    state_d = ST_WAIT_TX;
                else if (wd_timeout) state_d = ST_DONE;
            end
            ST_WAIT_TX: begin
                if (!uart_tx_busy)   state_d = (cnt_inc < len_q) ? ST_RD_REQ : ST_DONE;
                else if (wd_timeout) state_d = ST_DONE;
            end
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_re    = 1'b0;
        uart_we    = 1'b0;
        uart_addr  = '0;
        uart_wdata = '0;
        case (state_q)
            ST_CFG_BAUD: begin
                uart_we    = 1'b1;
                uart_addr  = UART_REG_BAUD;
                uart_wdata = BAUD_LO;
            end
            ST_CFG_CTRL, ST_WR_GO: begin
                uart_we    = 1'b1;
                uart_addr  = UART_REG_CTRL;
                uart_wdata = CTRL_TX_GO;
            end
            ST_RD_REQ: sram_re = 1'b1;
            ST_WR_DATA: begin
                uart_we    = 1'b1;
                uart_addr  = UART_REG_TXD;
                uart_wdata = data_q;
            end
            default: ;
        endcase
    end

    // Address wraps naturally at 2^AW; sent_cnt is one bit wider so it can reach len.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= base_addr;
                len_q  <= len;
                cnt_q  <= '0;
            end
            if (state_q == ST_RD_WAIT) begin
                data_q <= sram_rdata;
            end
            if (byte_done) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_inc;
            end
        end
    end

    assign sram_addr = addr_q;
    assign sent_cnt  = cnt_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule
